// File: rtl/synapse_weight_loader.sv
// rtl/synapse_weight_loader.sv - buffers (addr, weight, rc) entries and paces them onto the synapse write port
// One FIFO feeds a registered write port; an FSM sequences kill, paced issue, inter-write gaps and completion.
module synapse_weight_loader #(
  parameter int NUM_SYN     = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int KILL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear_first,
  input  logic [7:0]  exp_count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_addr,
  input  logic [7:0]  in_weight,
  input  logic        in_rc,
  output logic        kill,
  output logic [6:0]  iAddr,
  output logic [31:0] W_DATA,
  output logic        W_EN,
  output logic        R_EN,
  output logic        busy,
  output logic        done,
  output logic        err_addr,
  output logic [7:0]  wr_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int KW = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;
  localparam logic [KW-1:0] KILL_LAST  = KW'(KILL_CYCLES - 1);
  localparam logic [3:0]    GAP_LAST   = 4'(GAP_CYCLES - 1);
  localparam bit            HAS_GAP    = (GAP_CYCLES != 0);
  localparam logic [7:0]    ADDR_LIMIT = 8'(NUM_SYN);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KILL,
    S_LOAD,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occupancy;
  logic [7:0]    exp_q;
  logic [7:0]    accepted;
  logic [7:0]    consumed;
  logic [KW-1:0] kill_cnt;
  logic [3:0]    gap_cnt;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        kill_last;
  logic        gap_last;
  logic        finished;
  logic        head_ok;
  logic [15:0] head;
  logic [6:0]  head_addr;
  logic [7:0]  head_weight;
  logic        head_rc;

  assign fifo_full  = (occupancy == FULL_CNT);
  assign fifo_empty = (occupancy == '0);
  assign in_ready   = ((state == S_LOAD) || (state == S_GAP)) && !fifo_full && (accepted < exp_q);
  assign push       = in_valid && in_ready;

  assign head = mem[rd_ptr];
  assign {head_rc, head_weight, head_addr} = head;
  assign head_ok = ({1'b0, head_addr} < ADDR_LIMIT);

  assign kill_last = (kill_cnt == KILL_LAST);
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign finished  = (consumed == exp_q);

  // A pop loads the write port next edge; while a write is on the port the next pop waits for the gap's last cycle.
  assign pop = !fifo_empty &&
               (((state == S_LOAD) && !(W_EN && HAS_GAP)) || ((state == S_GAP) && gap_last));

  assign kill = (state == S_KILL);
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) state_nx = clear_first ? S_KILL : S_LOAD;
      end
      S_KILL: begin
        if (kill_last) state_nx = (exp_q == 8'd0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (W_EN && HAS_GAP) state_nx = S_GAP;
        else if (finished)   state_nx = S_DONE;
      end
      S_GAP: begin
        if (gap_last) state_nx = finished ? S_DONE : S_LOAD;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_rc, in_weight, in_addr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      exp_q     <= '0;
      accepted  <= '0;
      consumed  <= '0;
      kill_cnt  <= '0;
      gap_cnt   <= '0;
      W_EN      <= 1'b0;
      R_EN      <= 1'b0;
      iAddr     <= '0;
      W_DATA    <= '0;
      err_addr  <= 1'b0;
      wr_count  <= '0;
    end else begin
      state <= state_nx;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (AW + 1)'(1);
        2'b01:   occupancy <= occupancy - (AW + 1)'(1);
        default: occupancy <= occupancy;
      endcase

      kill_cnt <= (state == S_KILL) ? kill_cnt + KW'(1) : '0;
      gap_cnt  <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;

      // Out-of-range entries are consumed silently: no strobe, no gap, only the sticky error flag.
      W_EN <= pop && head_ok;
      R_EN <= pop && head_ok && head_rc;
      if (pop && head_ok) begin
        iAddr  <= head_addr;
        W_DATA <= {4{head_weight}};
      end

      if ((state == S_IDLE) && start) begin
        exp_q    <= exp_count;
        accepted <= '0;
        consumed <= '0;
        err_addr <= 1'b0;
        wr_count <= '0;
      end else begin
        if (push) accepted <= accepted + 8'd1;
        if (pop) begin
          consumed <= consumed + 8'd1;
          if (head_ok) wr_count <= wr_count + 8'd1;
          else         err_addr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_synapse_weight_loader.sv
// tb/tb_synapse_weight_loader.sv - directed self-checking bench for synapse_weight_loader
// Main instance uses NUM_SYN=100; a second instance with a long gap exercises FIFO backpressure.
module tb_synapse_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start_b;
  logic        clear_first;
  logic [7:0]  exp_count;
  logic        in_valid, in_valid_b;
  logic [6:0]  in_addr;
  logic [7:0]  in_weight;
  logic        in_rc;

  logic        in_ready, kill, W_EN, R_EN, busy, done, err_addr;
  logic [6:0]  iAddr;
  logic [31:0] W_DATA;
  logic [7:0]  wr_count;

  logic        b_in_ready, b_kill, b_wen, b_ren, b_busy, b_done, b_err;
  logic [6:0]  b_iaddr;
  logic [31:0] b_wdata;
  logic [7:0]  b_wrcnt;

  always #5 clk = ~clk;

  synapse_weight_loader #(.NUM_SYN(100)) u_dut (
    .clk(clk), .rst(rst), .start(start), .clear_first(clear_first), .exp_count(exp_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_weight(in_weight), .in_rc(in_rc),
    .kill(kill), .iAddr(iAddr), .W_DATA(W_DATA), .W_EN(W_EN), .R_EN(R_EN),
    .busy(busy), .done(done), .err_addr(err_addr), .wr_count(wr_count)
  );

  synapse_weight_loader #(.GAP_CYCLES(4)) u_bp (
    .clk(clk), .rst(rst), .start(start_b), .clear_first(clear_first), .exp_count(exp_count),
    .in_valid(in_valid_b), .in_ready(b_in_ready), .in_addr(in_addr), .in_weight(in_weight), .in_rc(in_rc),
    .kill(b_kill), .iAddr(b_iaddr), .W_DATA(b_wdata), .W_EN(b_wen), .R_EN(b_ren),
    .busy(b_busy), .done(b_done), .err_addr(b_err), .wr_count(b_wrcnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int kill_seen, done_seen, b_done_seen, ren_stray, ready_low, c0;
  int          wq_cyc[$];
  logic [6:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  logic        wq_rc[$];
  logic [6:0]  bq_addr[$];
  logic [31:0] bq_data[$];
  logic [6:0]  ea[8];
  logic [7:0]  ew[8];
  logic        er[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (W_EN) begin
      wq_addr.push_back(iAddr);
      wq_data.push_back(W_DATA);
      wq_rc.push_back(R_EN);
      wq_cyc.push_back(cyc);
    end
    if (R_EN && !W_EN) ren_stray++;
    if (kill) kill_seen++;
    if (done) done_seen++;
    if (b_wen) begin
      bq_addr.push_back(b_iaddr);
      bq_data.push_back(b_wdata);
    end
    if (b_done) b_done_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_log();
    wq_cyc.delete(); wq_addr.delete(); wq_data.delete(); wq_rc.delete();
    bq_addr.delete(); bq_data.delete();
    kill_seen = 0; done_seen = 0; b_done_seen = 0; ren_stray = 0; ready_low = 0;
    for (int i = 0; i < 8; i++) er[i] = 1'b0;
  endtask

  task automatic do_start(input bit sel, input bit cf, input logic [7:0] n);
    clear_first = cf;
    exp_count   = n;
    if (sel) start_b = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_b = 1'b0;
    c0 = cyc;
  endtask

  task automatic feed(input bit sel, input int n);
    int   i = 0;
    int   t = 0;
    logic rdy;
    while (i < n && t < 100) begin
      in_addr = ea[i]; in_weight = ew[i]; in_rc = er[i];
      if (sel) in_valid_b = 1'b1; else in_valid = 1'b1;
      @(negedge clk);
      rdy = sel ? b_in_ready : in_ready;
      if (!rdy) ready_low++;
      @(posedge clk); #1;
      if (rdy) i++;
      t++;
    end
    in_valid = 1'b0; in_valid_b = 1'b0;
    check("feed_accepted", 32'(i), 32'(n));
  endtask

  task automatic wait_done(input bit sel, input string tag);
    int t = 0;
    while (t < 200) begin
      @(negedge clk);
      if (sel ? b_done : done) break;
      t++;
    end
    check(tag, 32'(t < 200), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_b = 1'b0; clear_first = 1'b0; exp_count = '0;
    in_valid = 1'b0; in_valid_b = 1'b0; in_addr = '0; in_weight = '0; in_rc = 1'b0;
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 32'({in_ready, kill, W_EN, R_EN, busy, done, err_addr}), 32'd0);
    check("reset_iaddr", 32'(iAddr), 32'd0);
    check("reset_wdata", W_DATA, 32'd0);
    check("reset_wrcnt", 32'(wr_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Kill phase with an empty session
    clear_log();
    do_start(0, 1, 8'd0);
    wait_done(0, "kill_done_timeout");
    check("kill_cycles", 32'(kill_seen), 32'd2);
    check("kill_done_pulses", 32'(done_seen), 32'd1);
    check("kill_no_wen", 32'(wq_addr.size()), 32'd0);
    check("kill_wrcnt", 32'(wr_count), 32'd0);
    check("kill_idle", 32'(busy), 32'd0);

    // Four back-to-back entries, one-cycle gap
    clear_log();
    ea[0] = 7'd0; ea[1] = 7'd1; ea[2] = 7'd2; ea[3] = 7'd3;
    ew[0] = 8'h11; ew[1] = 8'h22; ew[2] = 8'h33; ew[3] = 8'h44;
    do_start(0, 0, 8'd4);
    feed(0, 4);
    wait_done(0, "b2b_done_timeout");
    check("b2b_count", 32'(wq_addr.size()), 32'd4);
    check("b2b_latency", 32'(wq_cyc[0]), 32'(c0 + 2));
    for (int i = 0; i < 4; i++) begin
      check("b2b_addr", 32'(wq_addr[i]), 32'(ea[i]));
      check("b2b_data", wq_data[i], {4{ew[i]}});
      if (i > 0) check("b2b_spacing", 32'(wq_cyc[i] - wq_cyc[i-1]), 32'd2);
    end
    check("b2b_wrcnt", 32'(wr_count), 32'd4);
    check("b2b_err", 32'(err_addr), 32'd0);
    check("b2b_done_pulses", 32'(done_seen), 32'd1);

    // Out-of-range entry is dropped
    clear_log();
    ea[0] = 7'd127; ew[0] = 8'h77; ea[1] = 7'd5; ew[1] = 8'h55;
    do_start(0, 0, 8'd2);
    feed(0, 2);
    wait_done(0, "oor_done_timeout");
    check("oor_count", 32'(wq_addr.size()), 32'd1);
    check("oor_addr", 32'(wq_addr[0]), 32'd5);
    check("oor_data", wq_data[0], 32'h55555555);
    check("oor_err", 32'(err_addr), 32'd1);
    check("oor_wrcnt", 32'(wr_count), 32'd1);
    check("oor_done_pulses", 32'(done_seen), 32'd1);

    // Rich-club entry
    clear_log();
    ea[0] = 7'd9; ew[0] = 8'hA5; er[0] = 1'b1;
    do_start(0, 0, 8'd1);
    feed(0, 1);
    wait_done(0, "rc_done_timeout");
    check("rc_count", 32'(wq_addr.size()), 32'd1);
    check("rc_ren", 32'(wq_rc[0]), 32'd1);
    check("rc_addr", 32'(wq_addr[0]), 32'd9);
    check("rc_data", wq_data[0], 32'hA5A5A5A5);
    check("rc_ren_stray", 32'(ren_stray), 32'd0);
    check("rc_err_cleared", 32'(err_addr), 32'd0);

    // Reset in the middle of a session
    clear_log();
    ea[0] = 7'd30; ea[1] = 7'd31; ea[2] = 7'd32;
    ew[0] = 8'h01; ew[1] = 8'h02; ew[2] = 8'h03;
    do_start(0, 0, 8'd8);
    feed(0, 3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_flags", 32'({in_ready, kill, W_EN, R_EN, busy, done, err_addr}), 32'd0);
    check("mid_rst_iaddr", 32'(iAddr), 32'd0);
    check("mid_rst_wdata", W_DATA, 32'd0);
    check("mid_rst_wrcnt", 32'(wr_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_log();
    ea[0] = 7'd40; ew[0] = 8'h3C;
    do_start(0, 0, 8'd1);
    feed(0, 1);
    wait_done(0, "post_rst_done_timeout");
    check("post_rst_count", 32'(wq_addr.size()), 32'd1);
    check("post_rst_addr", 32'(wq_addr[0]), 32'd40);
    check("post_rst_data", wq_data[0], 32'h3C3C3C3C);
    check("post_rst_wrcnt", 32'(wr_count), 32'd1);

    // Backpressure: valid held for six entries into a four-deep FIFO
    clear_log();
    for (int i = 0; i < 6; i++) begin
      ea[i] = 7'(10 + i);
      ew[i] = 8'(8'h61 + i);
    end
    do_start(1, 0, 8'd6);
    feed(1, 6);
    wait_done(1, "bp_done_timeout");
    check("bp_ready_dropped", 32'(ready_low > 0), 32'd1);
    check("bp_count", 32'(bq_addr.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("bp_addr", 32'(bq_addr[i]), 32'(ea[i]));
      check("bp_data", bq_data[i], {4{ew[i]}});
    end
    check("bp_wrcnt", 32'(b_wrcnt), 32'd6);
    check("bp_done_pulses", 32'(b_done_seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
